router_3x1_merge: RTL and testbench

//  Reverse-direction companion to the 1x3 router: merges three 8-bit byte streams into one.

---
 rtl/router_3x1_merge.sv | 128 ++++++++++++
 tb/tb_router_3x1_merge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_3x1_merge.sv
// Three-input byte merger: per-port FIFOs drained by a round-robin arbiter into a
// registered valid/ready output stage that tags each byte with its source port.
module router_3x1_merge #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in [3],
    input  logic [2:0]       valid_in,
    output logic [2:0]       ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       src_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q  [3][DEPTH];
    logic [PW-1:0]    wptr_q [3];
    logic [PW-1:0]    wptr_d [3];
    logic [PW-1:0]    rptr_q [3];
    logic [PW-1:0]    rptr_d [3];
    logic [CW-1:0]    cnt_q  [3];
    logic [CW-1:0]    cnt_d  [3];

    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       src_q, src_d;
    logic [1:0]       rr_q, rr_d;
    logic             valid_q, valid_d;

    logic [2:0]       wr, rd, ne;
    logic             load, found;
    logic [1:0]       grant;
    logic [WIDTH-1:0] head;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_port
        always_comb begin
            ne[i]        = (cnt_q[i] != '0);
            ready_out[i] = rst && (cnt_q[i] != CW'(DEPTH));
            wr[i]        = valid_in[i] && ready_out[i];
            wptr_d[i]    = wr[i] ? bump(wptr_q[i]) : wptr_q[i];
            rptr_d[i]    = rd[i] ? bump(rptr_q[i]) : rptr_q[i];
            case ({wr[i], rd[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end else begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end

        // Storage needs no reset: a slot is only read after it has been written.
        always_ff @(posedge clk) begin
            if (wr[i]) mem_q[i][wptr_q[i]] <= data_in[i];
        end
    end

    always_comb begin
        int unsigned idx;
        idx   = 0;
        load  = !valid_q || ready_in;
        found = 1'b0;
        grant = rr_q;
        // Search rr, rr+1, rr+2 (mod 3); first non-empty port wins.
        for (int unsigned k = 0; k < 3; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= 3) idx = idx - 3;
            if (!found && ne[idx[1:0]]) begin
                found = 1'b1;
                grant = idx[1:0];
            end
        end
        rd = '0;
        if (load && found) rd[grant] = 1'b1;
        head = mem_q[grant][rptr_q[grant]];
    end

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                data_d = head;
                src_d  = grant;
                rr_d   = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    assign data_out  = data_q;
    assign src_out   = src_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_router_3x1_merge.sv
// Bench for router_3x1_merge: queue-based reference model checked every cycle, directed
// scenarios pinned with literal output sequences, then a randomized traffic phase.
module tb_router_3x1_merge;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in [3];
    logic [2:0]       valid_in = '0;
    logic [2:0]       ready_out;
    logic [WIDTH-1:0] data_out;
    logic [1:0]       src_out;
    logic             valid_out;
    logic             ready_in = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [7:0] mq [3][$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = '0;
    logic [1:0] m_src   = '0;
    int         m_rr    = 0;
    logic [9:0] mlog [$];
    logic [9:0] exp_q [$];

    router_3x1_merge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .src_out   (src_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: FIFOs as queues, one output register, round-robin start index.
    always @(posedge clk or negedge rst) begin : model
        logic [2:0] acc;
        int         g;
        bit         fnd;
        if (!rst) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = '0;
            m_rr    = 0;
        end else begin
            for (int i = 0; i < 3; i++) acc[i] = valid_in[i] && (mq[i].size() < DEPTH);
            if (!m_valid || ready_in) begin
                fnd = 1'b0;
                g   = 0;
                for (int k = 0; k < 3; k++) begin
                    if (!fnd && mq[(m_rr + k) % 3].size() != 0) begin
                        fnd = 1'b1;
                        g   = (m_rr + k) % 3;
                    end
                end
                if (fnd) begin
                    m_data  = mq[g].pop_front();
                    m_src   = 2'(g);
                    m_valid = 1'b1;
                    m_rr    = (g + 1) % 3;
                    mlog.push_back({m_src, m_data});
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back(data_in[i]);
        end
    end

    always @(negedge clk) begin : compare
        logic [2:0] mready;
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) mready[i] = rst && (mq[i].size() < DEPTH);
            chk("valid_out", valid_out, m_valid);
            chk("data_out", data_out, m_data);
            chk("src_out", src_out, m_src);
            chk("ready_out", ready_out, mready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_in = '0;
        ready_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        mlog.delete();
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, mlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < mlog.size()) chk(nm, mlog[i], exp_q[i]);
        end
    endtask

    initial begin
        data_in = '{8'h00, 8'h00, 8'h00};

        // T1: reset holds everything off even with all inputs valid
        #2;
        rst      = 1'b0;
        cmp_en   = 1'b1;
        valid_in = 3'b111;
        data_in  = '{8'h01, 8'h02, 8'h03};
        ready_in = 1'b1;
        repeat (3) tick();
        chk("t1_valid", valid_out, 1'b0);
        chk("t1_ready", ready_out, 3'b000);
        valid_in = '0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        chk("t1_ready_rel", ready_out, 3'b111);
        tick();
        chk("t1_nowrite", valid_out, 1'b0);

        // T2: single byte on port 1
        valid_in[1] = 1'b1;
        data_in[1]  = 8'hA5;
        tick();
        valid_in = '0;
        tick();
        chk("t2_data", data_out, 8'hA5);
        chk("t2_src", src_out, 2'd1);
        chk("t2_valid", valid_out, 1'b1);
        tick();
        chk("t2_once", valid_out, 1'b0);

        // T3: round-robin across preloaded ports
        do_reset();
        valid_in = 3'b111;
        data_in  = '{8'h10, 8'h20, 8'h30};
        tick();
        valid_in   = 3'b101;
        data_in[0] = 8'h11;
        data_in[2] = 8'h31;
        tick();
        valid_in = '0;
        ready_in = 1'b1;
        repeat (8) tick();
        exp_q = '{10'h010, 10'h120, 10'h230, 10'h011, 10'h231};
        check_log("t3_order");

        // T4: output stall and port 0 filling up
        do_reset();
        valid_in   = 3'b001;
        data_in[0] = 8'h55;
        tick();
        valid_in = '0;
        tick();
        for (int b = 1; b <= 4; b++) begin
            data_in[0]  = 8'(b);
            valid_in[0] = 1'b1;
            chk("t4_hold_data", data_out, 8'h55);
            chk("t4_hold_src", src_out, 2'd0);
            chk("t4_hold_valid", valid_out, 1'b1);
            tick();
        end
        chk("t4_hold_data5", data_out, 8'h55);
        chk("t4_full", ready_out[0], 1'b0);
        data_in[0] = 8'h99;
        tick();
        tick();
        chk("t4_still_full", ready_out[0], 1'b0);
        valid_in = '0;
        ready_in = 1'b1;
        repeat (8) tick();
        exp_q = '{10'h055, 10'h001, 10'h002, 10'h003, 10'h004};
        check_log("t4_order");

        // T5: full port popped while a byte is offered
        do_reset();
        valid_in = 3'b100;
        for (int b = 0; b < 5; b++) begin
            data_in[2] = 8'hB0 + 8'(b);
            tick();
        end
        chk("t5_full", ready_out[2], 1'b0);
        data_in[2] = 8'h77;
        ready_in   = 1'b1;
        tick();
        chk("t5_reopen", ready_out[2], 1'b1);
        tick();
        valid_in = '0;
        repeat (10) tick();
        exp_q = '{10'h2B0, 10'h2B1, 10'h2B2, 10'h2B3, 10'h2B4, 10'h277};
        check_log("t5_order");

        // T6: asynchronous reset with bytes queued
        do_reset();
        valid_in = 3'b111;
        data_in  = '{8'hC0, 8'hC1, 8'hC2};
        tick();
        valid_in = '0;
        tick();
        chk("t6_pre", valid_out, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_drop", valid_out, 1'b0);
        chk("t6_ready", ready_out, 3'b000);
        tick();
        tick();
        rst = 1'b1;
        mlog.delete();
        valid_in   = 3'b010;
        data_in[1] = 8'hD1;
        ready_in   = 1'b1;
        tick();
        valid_in   = 3'b001;
        data_in[0] = 8'hD0;
        tick();
        valid_in = '0;
        repeat (5) tick();
        exp_q = '{10'h1D1, 10'h0D0};
        check_log("t6_order");

        // Randomized traffic with frequent backpressure
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            valid_in = 3'($urandom);
            for (int i = 0; i < 3; i++) data_in[i] = 8'($urandom);
            ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_in = '0;
        ready_in = 1'b1;
        repeat (20) tick();
        chk("rand_drained", valid_out, 1'b0);
        chk("rand_ready", ready_out, 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
